// File: rtl/w_stage_grf_if.sv
// W-stage bundle: pipeline register outputs in, decoded write-back and D-stage reads out.
// Latency: none; this only carries signals between the W register, the GRF and the D/hazard logic.
// Backpressure: none; the pipeline advances every cycle and nothing here can stall it.
interface w_stage_grf_if;
  logic [31:0] W_PC;
  logic [31:0] W_Instr;
  logic [31:0] W_DMRD;
  logic [31:0] W_ALUAns;
  logic [31:0] W_MDUAns;
  logic        W_b_jump;
  logic [4:0]  D_RA1;
  logic [4:0]  D_RA2;
  logic [31:0] D_RD1;
  logic [31:0] D_RD2;
  logic [4:0]  W_WA;
  logic [31:0] W_WD;
  logic        W_WE;

  // Pipeline side: drives the W inputs and read addresses, observes the results
  modport master (
    output W_PC, W_Instr, W_DMRD, W_ALUAns, W_MDUAns, W_b_jump, D_RA1, D_RA2,
    input  D_RD1, D_RD2, W_WA, W_WD, W_WE
  );

  // Write-back stage / register file side
  modport slave (
    input  W_PC, W_Instr, W_DMRD, W_ALUAns, W_MDUAns, W_b_jump, D_RA1, D_RA2,
    output D_RD1, D_RD2, W_WA, W_WD, W_WE
  );
endinterface

// File: rtl/w_stage_grf.sv
// Write-back decode/select/load-extend plus 32x32 GRF. Optional macro: GRF_INTERNAL_BYPASS_EN.
// Latency: decode and reads are combinational; the GRF commits on the rising clk edge.
// Backpressure: none; one W instruction retires every cycle.
module w_stage_grf (
  input  logic          clk,
  input  logic          reset,
  w_stage_grf_if.slave  bus
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] pc_plus8;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  wa;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] grf [0:31];
  logic        unused_fields;

  assign op       = bus.W_Instr[31:26];
  assign funct    = bus.W_Instr[5:0];
  assign rt       = bus.W_Instr[20:16];
  assign rd       = bus.W_Instr[15:11];
  assign pc_plus8 = bus.W_PC + 32'd8;

  // rs and shamt never matter to the write-back decision
  assign unused_fields = ^{bus.W_Instr[25:21], bus.W_Instr[10:6]};

  // Little-endian lane pick; ALUAns[0] is ignored for halves (no alignment trap)
  always_comb begin
    ld_byte = bus.W_DMRD[7:0];
    case (bus.W_ALUAns[1:0])
      2'd0: ld_byte = bus.W_DMRD[7:0];
      2'd1: ld_byte = bus.W_DMRD[15:8];
      2'd2: ld_byte = bus.W_DMRD[23:16];
      2'd3: ld_byte = bus.W_DMRD[31:24];
      default: ld_byte = bus.W_DMRD[7:0];
    endcase
    ld_half = bus.W_ALUAns[1] ? bus.W_DMRD[31:16] : bus.W_DMRD[15:0];
  end

  // Destination decode and write-back source select
  always_comb begin
    wa    = 5'd0;
    wdata = 32'd0;
    case (op)
      OP_LW:  begin wa = rt; wdata = bus.W_DMRD; end
      OP_LH:  begin wa = rt; wdata = {{16{ld_half[15]}}, ld_half}; end
      OP_LHU: begin wa = rt; wdata = {16'd0, ld_half}; end
      OP_LB:  begin wa = rt; wdata = {{24{ld_byte[7]}}, ld_byte}; end
      OP_LBU: begin wa = rt; wdata = {24'd0, ld_byte}; end
      OP_JAL: begin wa = 5'd31; wdata = pc_plus8; end
      OP_REGIMM: begin
        // bltzal/bgezal link only when the branch was actually taken
        if ((rt == 5'b10000 || rt == 5'b10001) && bus.W_b_jump) begin
          wa    = 5'd31;
          wdata = pc_plus8;
        end
      end
      OP_SPECIAL: begin
        if (funct == 6'b010000 || funct == 6'b010010) begin
          wa    = rd;
          wdata = bus.W_MDUAns;
        end else if (funct == 6'b001001) begin
          wa    = rd;
          wdata = pc_plus8;
        end else if (funct[5] || funct == 6'b000000 || funct == 6'b000010 ||
                     funct == 6'b000011 || funct == 6'b000100 ||
                     funct == 6'b000110 || funct == 6'b000111) begin
          wa    = rd;
          wdata = bus.W_ALUAns;
        end
      end
      default: begin
        if (op[5:3] == 3'b001) begin
          wa    = rt;
          wdata = bus.W_ALUAns;
        end
      end
    endcase
  end

  // $0 as destination means no write, and the data bus is forced quiet
  assign we       = (wa != 5'd0);
  assign bus.W_WA = wa;
  assign bus.W_WE = we;
  assign bus.W_WD = we ? wdata : 32'd0;

  // Register array: async clear, commit on the edge; entry 0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) grf[i] <= 32'd0;
    end else if (we) begin
      grf[wa] <= wdata;
    end
  end

  // D-stage read ports, zero while reset is held
`ifdef GRF_INTERNAL_BYPASS_EN
  always_comb begin
    bus.D_RD1 = grf[bus.D_RA1];
    bus.D_RD2 = grf[bus.D_RA2];
    if (we && bus.D_RA1 == wa) bus.D_RD1 = wdata;
    if (we && bus.D_RA2 == wa) bus.D_RD2 = wdata;
    if (!reset) begin
      bus.D_RD1 = 32'd0;
      bus.D_RD2 = 32'd0;
    end
  end
`else
  always_comb begin
    bus.D_RD1 = reset ? grf[bus.D_RA1] : 32'd0;
    bus.D_RD2 = reset ? grf[bus.D_RA2] : 32'd0;
  end
`endif

endmodule

// File: doc/w_stage_grf.md
# w_stage_grf

Write-back stage and general register file of the five-stage MIPS pipeline. Consumes the W-stage pipeline register outputs (PC, instruction, DM read word, ALU result, MDU result, branch-taken flag) and decodes the destination register. Selects and load-extends the write-back value and commits it to 32×32-bit GRF storage. Provides the two D-stage read ports and exports the committed write (address, data, enable) to the hazard/forwarding unit.

## Interface
Parameters:
- none

Ports:
- clk  input  1  pipeline clock; GRF writes on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all registers immediately
- W_PC  input  32  PC of instruction in W
- W_Instr  input  32  instruction in W
- W_DMRD  input  32  raw aligned word read from DM
- W_ALUAns  input  32  ALU result; also load address, bits [1:0] select byte/half
- W_MDUAns  input  32  HI or LO value for mfhi/mflo
- W_b_jump  input  1  conditional link branch was taken
- D_RA1  input  5  read address 1
- D_RA2  input  5  read address 2
- D_RD1  output  32  read data 1
- D_RD2  output  32  read data 2
- W_WA  output  5  decoded destination; 0 if no write
- W_WD  output  32  selected/extended write data
- W_WE  output  1  write commits this cycle (W_WA≠0)

## Operation
- Decode, from W_Instr op[31:26] / funct[5:0] / rt[20:16]:
  - loads lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100 → WA=rt, data=extended DMRD
  - I-type ALU, op[5:3]=001 → WA=rt, data=ALUAns
  - op 000000: funct 010000 mfhi / 010010 mflo → WA=rd, data=MDUAns
  - op 000000: funct 001001 jalr → WA=rd, data=PC+8
  - op 000000: funct[5]=1, or funct ∈ {000000,000010,000011,000100,000110,000111} → WA=rd, data=ALUAns
  - jal 000011 → WA=31, data=PC+8
  - op 000001, rt 10000/10001 (bltzal/bgezal) → WA=31, data=PC+8 only if W_b_jump=1, else WA=0
  - all other encodings → WA=0
- Load extension, little-endian:
  - lb/lbu select byte ALUAns[1:0]; lh/lhu select half ALUAns[1]
  - lb/lh sign-extend; lbu/lhu zero-extend
  - ALUAns[0] ignored for halves; no alignment exception
- W_WE = (W_WA≠0). W_WD is valid whenever W_WE=1; when W_WE=0, W_WD=0.
- $0 reads 0 always; writes to $0 are dropped.
- PC+8 is a 32-bit add with wrap-around modulo 2^32.

## Timing
- Write: GRF[W_WA] ← W_WD on rising clk when W_WE=1 and reset=1.
- Read: D_RD1/D_RD2 are combinational from the register array and RA.
- Decode, W_WA, W_WD, W_WE: purely combinational from W inputs, zero latency.
- Reset:
  - reset=0 asynchronously clears GRF[1..31] to 0; D_RD* read 0 while asserted.
  - W_WA/W_WD/W_WE follow the inputs; the W register upstream presents nop (0) during reset, giving 0/0/0.
  - A write edge coinciding with reset=0 is lost.
  - Release is synchronous to the next edge only in effect: the first write occurs at the first rising clk with reset=1.
- Same-cycle read/write of the same nonzero address: governed by the configuration option below.

## Configuration
- GRF_INTERNAL_BYPASS_EN:
  - Defined: if W_WE=1 and D_RAx==W_WA≠0, D_RDx returns W_WD in the same cycle, so the W→D hazard needs no external forwarding.
  - Undefined: D_RDx returns the old array value until the edge; the hazard unit forwards W_WD to D.

## Test plan
- Reset: write $5=0x1234, pulse reset=0 mid-cycle without clk → D_RD1 (RA1=5) reads 0 immediately; W_WE=0 with nop.
- lb/lbu/lh: DMRD=0x80FF7F01, ALUAns low bits 2'b11 → lb writes 0xFFFFFF80, lbu writes 0x00000080; lh with ALUAns[1]=0 writes 0x00007F01.
- jal at PC=0xFFFFFFFC → $31=0x00000004 (wrap); bgezal with W_b_jump=0 → W_WE=0, $31 unchanged; with W_b_jump=1 → $31=PC+8.
- mflo with MDUAns=0xDEADBEEF, rd=9 → $9=0xDEADBEEF; addu with rd=0 → W_WE=0, $0 reads 0.
- Same-cycle ori rt=7, ALUAns=0x55 with RA2=7:
  - with GRF_INTERNAL_BYPASS_EN → D_RD2=0x55 before the edge
  - without it → D_RD2 holds the old value until after the edge
- Non-writing instructions (sw, beq, jr, mult, mthi) → W_WA=0, W_WE=0, no GRF change.
